// File: rtl/clause_array_ctrl.sv
// Controller for a clause array: clears every row, loads clauses one row per
// transfer, and reads the loaded rows back through a valid/ready stream.
module clause_array_ctrl #(
  parameter int NUM_LITS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_CNT   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_load_i,
  input  logic                              clause_valid_i,
  output logic                              clause_ready_o,
  input  logic [NUM_LITS*2-1:0]             clause_i,
  input  logic                              clause_last_i,
  output logic [NUM_CLAUSES-1:0]            wr_o,
  output logic [NUM_LITS*2-1:0]             lit_o,
  input  logic                              start_read_i,
  input  logic [NUM_CLAUSES*NUM_LITS*2-1:0] rd_lit_i,
  output logic                              rd_valid_o,
  input  logic                              rd_ready_i,
  output logic [NUM_LITS*2-1:0]             rd_clause_o,
  output logic                              rd_last_o,
  output logic [WIDTH_CNT-1:0]              num_clauses_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              overflow_o
);

  localparam int LW = NUM_LITS * 2;
  localparam int CW = $clog2(NUM_CLAUSES);
  localparam logic [WIDTH_CNT-1:0]   FULL_CNT = WIDTH_CNT'(NUM_CLAUSES);
  localparam logic [CW-1:0]          LAST_ROW = CW'(NUM_CLAUSES - 1);
  localparam logic [NUM_CLAUSES-1:0] ROW0     = NUM_CLAUSES'(1);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, READ} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          clr_idx_q, clr_idx_d;
  logic [WIDTH_CNT-1:0]   cnt_q, cnt_d;
  logic [WIDTH_CNT-1:0]   rd_idx_q, rd_idx_d;
  logic [NUM_CLAUSES-1:0] wr_q, wr_d;
  logic [LW-1:0]          lit_q, lit_d;
  logic                   ready_q, ready_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [LW-1:0]          rd_clause_q, rd_clause_d;
  logic                   rd_last_q, rd_last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic [LW-1:0]          rd_row;

  // Row mux for readback; rows past the loaded count are never selected.
  always_comb begin
    rd_row = '0;
    for (int r = 0; r < NUM_CLAUSES; r++) begin
      if (rd_idx_q == WIDTH_CNT'(r)) rd_row = rd_lit_i[r*LW +: LW];
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    cnt_d       = cnt_q;
    rd_idx_d    = rd_idx_q;
    wr_d        = '0;
    lit_d       = '0;
    rd_valid_d  = rd_valid_q;
    rd_clause_d = rd_clause_q;
    rd_last_d   = rd_last_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start_load_i) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          clr_idx_d  = '0;
          overflow_d = 1'b0;
          wr_d       = ROW0;
        end else if (start_read_i) begin
          state_d    = READ;
          rd_idx_d   = '0;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
      end

      CLEAR: begin
        if (clr_idx_q == LAST_ROW) begin
          state_d = LOAD;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
          wr_d      = ROW0 << clr_idx_d;
        end
      end

      LOAD: begin
        if (clause_valid_i && ready_q) begin
          wr_d  = ROW0 << cnt_q;
          lit_d = clause_i;
          cnt_d = cnt_q + 1'b1;
          if (clause_last_i) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_q == FULL_CNT) begin
          // Array filled without a last clause; the final write has landed.
          overflow_d = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      READ: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!rd_valid_q) begin
          rd_clause_d = rd_row;
          rd_valid_d  = 1'b1;
          rd_last_d   = (rd_idx_q == cnt_q - 1'b1);
        end else if (rd_ready_i) begin
          rd_valid_d = 1'b0;
          if (rd_last_q) begin
            rd_last_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD) && (cnt_d < FULL_CNT);
    busy_d  = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_idx_q   <= '0;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      wr_q        <= '0;
      lit_q       <= '0;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_clause_q <= '0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      wr_q        <= wr_d;
      lit_q       <= lit_d;
      ready_q     <= ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_clause_q <= rd_clause_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign clause_ready_o = ready_q;
  assign wr_o           = wr_q;
  assign lit_o          = lit_q;
  assign rd_valid_o     = rd_valid_q;
  assign rd_clause_o    = rd_clause_q;
  assign rd_last_o      = rd_last_q;
  assign num_clauses_o  = cnt_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign overflow_o     = overflow_q;

endmodule

// File: doc/clause_array_ctrl.md
CLAUSE_ARRAY_CTRL -- requirements
Module: clause_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_LITS, default 8: literal cells per clause row; power of two, at least 2.
REQ-002 SHALL have parameter NUM_CLAUSES, default 8: clause rows in the array; power of two, at least 2.
REQ-003 SHALL have parameter WIDTH_CNT, default 4: width of the row count; NUM_CLAUSES SHALL be less than 2^WIDTH_CNT.
REQ-004 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_load_i  in  1  begin clear+load sequence.
- clause_valid_i  in  1  clause_i valid.
- clause_ready_o  out  1  controller accepts clause_i.
- clause_i  in  NUM_LITS*2  one clause, 2 bits per literal; 2'b00 = empty cell.
- clause_last_i  in  1  final clause of the load.
- wr_o  out  NUM_CLAUSES  one-hot row write strobe, driving each row's wr_i.
- lit_o  out  NUM_LITS*2  write data, driving each row's lit_i.
- start_read_i  in  1  begin readback.
- rd_lit_i  in  NUM_CLAUSES*NUM_LITS*2  concatenated row lit_o; row r occupies bits [r*NUM_LITS*2 +: NUM_LITS*2].
- rd_valid_o  out  1  rd_clause_o valid.
- rd_ready_i  in  1  consumer accepts rd_clause_o.
- rd_clause_o  out  NUM_LITS*2  row read back.
- rd_last_o  out  1  rd_clause_o is the last loaded row.
- num_clauses_o  out  WIDTH_CNT  rows loaded by the last load.
- busy_o  out  1  FSM not IDLE.
- done_o  out  1  one-cycle pulse at the end of a load or readback.
- overflow_o  out  1  sticky; set when the array filled before clause_last_i.

Function
REQ-005 SHALL implement the FSM states IDLE, CLEAR, LOAD and READ; busy_o SHALL equal (state != IDLE).
REQ-006 In IDLE, start_load_i SHALL move the FSM to CLEAR, zero the row counter, and clear num_clauses_o and overflow_o.
REQ-007 In IDLE, start_read_i without start_load_i SHALL move the FSM to READ with the read index at 0.
REQ-008 start_load_i SHALL take priority when asserted in the same cycle as start_read_i.
REQ-009 start_load_i and start_read_i SHALL be ignored outside IDLE.
REQ-010 CLEAR SHALL last exactly NUM_CLAUSES cycles, asserting wr_o = 1<<k with lit_o = 0 in cycle k, then move to LOAD.
REQ-011 clause_ready_o SHALL be asserted only in LOAD and only while the row counter is below NUM_CLAUSES.
REQ-012 A clause transfer SHALL occur when clause_valid_i and clause_ready_o are both high.
REQ-013 A transfer in cycle N SHALL produce, in cycle N+1, wr_o = 1<<row and lit_o = the captured clause_i, and the row counter SHALL increment.
REQ-014 wr_o SHALL be zero in every cycle without such a write; at most one wr_o bit SHALL ever be set.
REQ-015 A transfer with clause_last_i high SHALL return the FSM to IDLE after its write cycle, with done_o pulsed in that write cycle.
REQ-016 If the counter reaches NUM_CLAUSES with no last transfer, the FSM SHALL set overflow_o, pulse done_o and return to IDLE in the cycle after the final write.
REQ-017 num_clauses_o SHALL equal the row counter and SHALL hold its value in IDLE and READ.
REQ-018 READ with num_clauses_o = 0 SHALL pulse done_o one cycle after entry, return to IDLE, and never assert rd_valid_o.
REQ-019 In READ, rd_clause_o SHALL be registered from row index idx of rd_lit_i, with rd_valid_o rising one cycle after idx is set.
REQ-020 rd_clause_o and rd_last_o SHALL remain stable while rd_valid_o is high and rd_ready_i is low.
REQ-021 rd_last_o SHALL be high when idx = num_clauses_o-1.
REQ-022 On acceptance (rd_valid_o and rd_ready_i) of a non-last row, idx SHALL increment and rd_valid_o SHALL drop for one cycle; rd_valid_o SHALL therefore be high in at most every other cycle.
REQ-023 On acceptance of the last row, the FSM SHALL pulse done_o in the next cycle and return to IDLE.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst high at a clock edge SHALL force state=IDLE and all outputs to 0: wr_o, lit_o, clause_ready_o, rd_valid_o, rd_clause_o, rd_last_o, num_clauses_o, busy_o, done_o and overflow_o.
REQ-026 rst SHALL override any in-progress CLEAR, LOAD or READ in the same cycle; a pending write SHALL be dropped.

Verification
REQ-027 Load with NUM_CLAUSES=8: start_load_i -> exactly 8 clear strobes 0x01..0x80 with lit_o=0; then 3 clauses, last on the 3rd -> wr_o 0x01, 0x02, 0x04 with matching lit_o; done_o pulses once; num_clauses_o=3; overflow_o=0.
REQ-028 Overflow: 9 clauses offered, none marked last -> 8 writes; clause_ready_o stays low for the 9th; overflow_o=1; num_clauses_o=8; done_o pulses once.
REQ-029 Readback of 3 rows with rd_ready_i low for 2 cycles on row 1 -> rd_clause_o holds row 1 data; rows come out in order 0,1,2; rd_last_o high only on row 2; done_o pulses after the row 2 acceptance.
REQ-030 Zero-row read: start_read_i after reset -> no rd_valid_o; done_o pulses one cycle after entry; back in IDLE.
REQ-031 start_load_i and start_read_i in the same cycle -> CLEAR is entered; a start_read_i during LOAD is ignored.
REQ-032 rst asserted mid-LOAD after 2 writes -> next cycle all outputs 0 and state=IDLE; a following start_read_i yields an immediate done_o with no data.
